// File: rtl/wb_slave_pipelined_ram_if.sv
// Wishbone pipelined bus bundle between a master and the RAM slave.
interface wb_slave_pipelined_ram_if #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16
);
    logic                   wb_cyc;
    logic                   wb_stb;
    logic                   wb_we;
    logic [ADR_WIDTH-1:0]   wb_adr;
    logic [DAT_WIDTH/8-1:0] wb_sel;
    logic [DAT_WIDTH-1:0]   wb_dat_i;
    logic [DAT_WIDTH-1:0]   wb_dat_o;
    logic                   wb_ack;
    logic                   wb_stall;
    logic                   wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_stall, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        output wb_dat_o, wb_ack, wb_stall, wb_err
    );
endinterface

// File: rtl/wb_slave_pipelined_ram.sv
// Pipelined Wishbone RAM slave, fixed accept-to-ack latency, bounded outstanding.
// Define WB_SLAVE_ERR_EN to answer addresses >= DEPTH with wb_err.
module wb_slave_pipelined_ram #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_slave_pipelined_ram_if.slave wb
);
    localparam int SW = DAT_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    logic                 accept;
    logic                 req_err;
    logic                 done;
    logic [IW-1:0]        idx;
    logic [DAT_WIDTH-1:0] rdata;
    logic [DAT_WIDTH-1:0] in_dat;

    logic [LATENCY-1:0] vld_q, vld_d, vld_sh;
    logic [LATENCY-1:0] err_q, err_d, err_sh;
    logic [LATENCY-1:0][DAT_WIDTH-1:0] dat_q, dat_d, dat_sh;
    logic [CW-1:0] cnt_q, cnt_d;

    assign idx = wb.wb_adr[IW-1:0];

`ifdef WB_SLAVE_ERR_EN
    assign req_err = {1'b0, wb.wb_adr} >= (ADR_WIDTH + 1)'(DEPTH);
`else
    assign req_err = 1'b0;
`endif

    assign wb.wb_stall = (cnt_q == CW'(MAX_OUT));
    assign accept = rst & wb.wb_cyc & wb.wb_stb & ~wb.wb_stall;
    assign rdata  = mem[idx];
    assign in_dat = (accept & ~wb.wb_we & ~req_err) ? rdata : '0;

    // Stage 0 is loaded at the accept edge; the last stage drives the bus.
    if (LATENCY == 1) begin : g_lat1
        assign vld_sh = accept;
        assign err_sh = accept & req_err;
        assign dat_sh = in_dat;
    end else begin : g_latn
        assign vld_sh = {vld_q[LATENCY-2:0], accept};
        assign err_sh = {err_q[LATENCY-2:0], accept & req_err};
        assign dat_sh = {dat_q[LATENCY-2:0], in_dat};
    end

    // A request stops counting once its completion reaches the output stage.
    assign done = vld_sh[LATENCY-1];

    always_comb begin
        vld_d = vld_sh;
        err_d = err_sh;
        dat_d = dat_sh;
        cnt_d = cnt_q;
        if (!wb.wb_cyc) begin
            vld_d = '0;
            err_d = '0;
            dat_d = '0;
            cnt_d = '0;
        end else begin
            unique case ({accept, done})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            err_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wb.wb_we && !req_err) begin
            for (int b = 0; b < SW; b++) begin
                if (wb.wb_sel[b]) begin
                    mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_ack   = vld_q[LATENCY-1] & ~err_q[LATENCY-1];
    assign wb.wb_err   = vld_q[LATENCY-1] & err_q[LATENCY-1];
    assign wb.wb_dat_o = dat_q[LATENCY-1];
endmodule

// File: tb/tb_wb_slave_pipelined_ram.sv
// Scoreboard bench for wb_slave_pipelined_ram: default instance plus a MAX_OUT=1 instance.
`timescale 1ns/1ps
module tb_wb_slave_pipelined_ram;
    localparam int LAT = 2;
`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_slave_pipelined_ram_if #(.ADR_WIDTH(16), .DAT_WIDTH(16)) bus_a ();
    wb_slave_pipelined_ram_if #(.ADR_WIDTH(16), .DAT_WIDTH(16)) bus_b ();

    wb_slave_pipelined_ram #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .DEPTH(1024), .LATENCY(LAT), .MAX_OUT(4)
    ) u_dut (
        .clk(clk), .rst(rst), .wb(bus_a)
    );

    wb_slave_pipelined_ram #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .DEPTH(1024), .LATENCY(2), .MAX_OUT(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .wb(bus_b)
    );

    typedef struct {
        logic        err;
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion on bus A is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (bus_a.wb_ack || bus_a.wb_err)) begin
            chk("ack_err_exclusive", {31'd0, bus_a.wb_ack & bus_a.wb_err}, 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_completion: ack=%0b err=%0b with empty queue (cycle %0d)",
                         bus_a.wb_ack, bus_a.wb_err, cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_err", {31'd0, bus_a.wb_err}, {31'd0, e.err});
                chk("resp_dat", {16'd0, bus_a.wb_dat_o}, {16'd0, e.dat});
                chk("resp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic req(input logic we, input logic [15:0] adr, input logic [1:0] sel,
                       input logic [15:0] dat, input logic xerr, input logic [15:0] xdat,
                       input bit push, input bit nostall);
        int w = 0;
        bus_a.wb_cyc   = 1'b1;
        bus_a.wb_stb   = 1'b1;
        bus_a.wb_we    = we;
        bus_a.wb_adr   = adr;
        bus_a.wb_sel   = sel;
        bus_a.wb_dat_i = dat;
        while (bus_a.wb_stall && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (nostall) chk("burst_no_stall", w, 0);
        if (w >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL stall_timeout: waited %0d cycles, required < 20", w);
        end
        if (push) sb.push_back('{err: xerr, dat: xdat, cyc: cyc + LAT});
        @(negedge clk);
        bus_a.wb_stb = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic end_cyc();
        bus_a.wb_cyc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bus_a.wb_cyc = 0; bus_a.wb_stb = 0; bus_a.wb_we = 0;
        bus_a.wb_adr = 0; bus_a.wb_sel = 0; bus_a.wb_dat_i = 0;
        bus_b.wb_cyc = 0; bus_b.wb_stb = 0; bus_b.wb_we = 0;
        bus_b.wb_adr = 0; bus_b.wb_sel = 0; bus_b.wb_dat_i = 0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, bus_a.wb_ack}, 0);
        chk("rst_err", {31'd0, bus_a.wb_err}, 0);
        chk("rst_dat", {16'd0, bus_a.wb_dat_o}, 0);
        chk("rst_stall", {31'd0, bus_a.wb_stall}, 0);
        chk("rst_b_stall", {31'd0, bus_b.wb_stall}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 10; i++) begin
            req(1'b1, 16'(i), 2'b11, 16'(100 + i), 1'b0, 16'd0, 1'b1, 1'b0);
            drain();
            end_cyc();
        end
        for (int i = 1; i <= 10; i++) begin
            req(1'b0, 16'(i), 2'b00, 16'd0, 1'b0, 16'(100 + i), 1'b1, 1'b0);
            drain();
            end_cyc();
        end

        for (int i = 1; i <= 10; i++)
            req(1'b1, 16'(10 + i), 2'b11, 16'(210 + i), 1'b0, 16'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++)
            req(1'b0, 16'(10 + i), 2'b00, 16'd0, 1'b0, 16'(210 + i), 1'b1, 1'b1);
        drain();
        end_cyc();

        req(1'b1, 16'd5, 2'b11, 16'hAAAA, 1'b0, 16'd0, 1'b1, 1'b0);
        req(1'b1, 16'd5, 2'b01, 16'h1234, 1'b0, 16'd0, 1'b1, 1'b0);
        req(1'b0, 16'd5, 2'b00, 16'd0, 1'b0, 16'hAA34, 1'b1, 1'b0);
        req(1'b1, 16'd30, 2'b11, 16'h5A5A, 1'b0, 16'd0, 1'b1, 1'b1);
        req(1'b0, 16'd30, 2'b11, 16'd0, 1'b0, 16'h5A5A, 1'b1, 1'b1);
        drain();
        end_cyc();

        // A read accepted, then the cycle is dropped before its ack.
        bus_a.wb_cyc = 1; bus_a.wb_stb = 1; bus_a.wb_we = 0;
        bus_a.wb_adr = 16'd1; bus_a.wb_sel = 0;
        @(negedge clk);
        bus_a.wb_cyc = 0; bus_a.wb_stb = 0;
        repeat (4) begin
            @(negedge clk);
            chk("flush_no_ack", {31'd0, bus_a.wb_ack}, 0);
        end
        chk("flush_stall", {31'd0, bus_a.wb_stall}, 0);
        req(1'b0, 16'd2, 2'b00, 16'd0, 1'b0, 16'd102, 1'b1, 1'b1);
        drain();
        end_cyc();

        // Reset lands while a write is in flight.
        bus_a.wb_cyc = 1; bus_a.wb_stb = 1; bus_a.wb_we = 1;
        bus_a.wb_adr = 16'd40; bus_a.wb_sel = 2'b11; bus_a.wb_dat_i = 16'h4444;
        @(negedge clk);
        bus_a.wb_stb = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_ack", {31'd0, bus_a.wb_ack}, 0);
        chk("midrst_dat", {16'd0, bus_a.wb_dat_o}, 0);
        chk("midrst_stall", {31'd0, bus_a.wb_stall}, 0);
        @(negedge clk);
        chk("midrst_ack_late", {31'd0, bus_a.wb_ack}, 0);
        req(1'b0, 16'd40, 2'b00, 16'd0, 1'b0, 16'h4444, 1'b1, 1'b0);
        drain();
        end_cyc();

        req(1'b1, 16'd0, 2'b11, 16'h0F0F, 1'b0, 16'd0, 1'b1, 1'b0);
        req(1'b1, 16'd1024, 2'b11, 16'hBEEF, ERR_EN, 16'd0, 1'b1, 1'b0);
        req(1'b0, 16'd0, 2'b00, 16'd0, 1'b0, ERR_EN ? 16'h0F0F : 16'hBEEF, 1'b1, 1'b0);
        drain();
        end_cyc();

        // MAX_OUT=1 instance: one accept every two cycles.
        bus_b.wb_cyc = 1; bus_b.wb_stb = 1; bus_b.wb_we = 1;
        bus_b.wb_adr = 16'd3; bus_b.wb_sel = 2'b11; bus_b.wb_dat_i = 16'h0033;
        @(negedge clk);
        chk("b_stall_after_write", {31'd0, bus_b.wb_stall}, 1);
        bus_b.wb_stb = 0;
        @(negedge clk);
        chk("b_write_ack", {31'd0, bus_b.wb_ack}, 1);
        @(negedge clk);
        bus_b.wb_we = 0; bus_b.wb_sel = 0; bus_b.wb_stb = 1;
        acks = 0;
        for (int j = 0; j <= 8; j++) begin
            chk("b_stall", {31'd0, bus_b.wb_stall}, (j % 2 == 1) ? 1 : 0);
            chk("b_ack", {31'd0, bus_b.wb_ack}, (j >= 2 && j % 2 == 0) ? 1 : 0);
            if (bus_b.wb_ack) begin
                acks++;
                chk("b_dat", {16'd0, bus_b.wb_dat_o}, 32'h0033);
            end
            if (j == 7) bus_b.wb_stb = 0;
            if (j < 8) @(negedge clk);
        end
        chk("b_ack_total", acks, 4);
        bus_b.wb_cyc = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_slave_pipelined_ram.md
WB_SLAVE_PIPELINED_RAM -- requirements
Module: wb_slave_pipelined_ram

Interface
REQ-001 SHALL: parameter ADR_WIDTH, default 16, word address width.
REQ-002 SHALL: parameter DAT_WIDTH, default 16, data width, multiple of 8.
REQ-003 SHALL: parameter DEPTH, default 1024, memory words, power of two, DEPTH <= 2**ADR_WIDTH.
REQ-004 SHALL: parameter LATENCY, default 2, accept-to-ack cycles, range 1..4.
REQ-005 SHALL: parameter MAX_OUT, default 4, max outstanding requests, range 1..8.
REQ-006 SHALL: clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL: rst  in  1  reset, synchronous, active-low (rst=0 resets on clk edge).
REQ-008 SHALL: wb_cyc  in  1  bus cycle valid.
REQ-009 SHALL: wb_stb  in  1  request strobe.
REQ-010 SHALL: wb_we  in  1  1=write, 0=read.
REQ-011 SHALL: wb_adr  in  ADR_WIDTH  word address.
REQ-012 SHALL: wb_sel  in  DAT_WIDTH/8  byte-lane enables for writes.
REQ-013 SHALL: wb_dat_i  in  DAT_WIDTH  write data.
REQ-014 SHALL: wb_dat_o  out  DAT_WIDTH  read data, valid only while wb_ack=1.
REQ-015 SHALL: wb_ack  out  1  one-cycle completion per accepted request.
REQ-016 SHALL: wb_stall  out  1  slave cannot accept this cycle.
REQ-017 SHALL: wb_err  out  1  error completion (see Configuration).

Function
REQ-018 SHALL: request accepted at an edge where wb_cyc & wb_stb & !wb_stall; one accept per cycle max.
REQ-019 SHALL: accepted write commits at the accept edge, only lanes with wb_sel=1 updated; wb_sel ignored for reads.
REQ-020 SHALL: accepted read samples memory at the accept edge; read after write to same address in next cycle returns the new data.
REQ-021 SHALL: request accepted at edge k completes with wb_ack (or wb_err) high for exactly the cycle following edge k+LATENCY-1, i.e. LATENCY cycles after accept; completions strictly in accept order.
REQ-022 SHALL: wb_dat_o = read word during read ack; 0 during write ack, err, or idle.
REQ-023 SHALL: outstanding counter +1 on accept, -1 on completion, unchanged when both occur in the same edge; wb_stall = (counter == MAX_OUT), combinational from counter.
REQ-024 SHALL: with MAX_OUT >= LATENCY, back-to-back requests sustain one accept per cycle with wb_stall never asserted.
REQ-025 SHALL: wb_cyc=0 at an edge flushes all pending completions (no ack/err issued for them), counter to 0; committed writes remain.
REQ-026 SHALL: wb_stb while wb_cyc=0 ignored.
REQ-027 SHALL: wb_ack and wb_err never high in the same cycle.

Reset
REQ-028 SHALL: at rst=0 edge: wb_ack=0, wb_err=0, wb_dat_o=0, counter=0, wb_stall=0, pipeline emptied.
REQ-029 SHALL: reset mid-transfer discards pending completions; memory contents not reset, writes already committed retained.

Configuration
REQ-030 SHALL: macro WB_SLAVE_ERR_EN defined: address >= DEPTH completes with wb_err (not wb_ack) at same latency, write suppressed, wb_dat_o=0.
REQ-031 SHALL: WB_SLAVE_ERR_EN undefined: address index = wb_adr mod DEPTH, always wb_ack; wb_err tied 0.

Verification
REQ-032 SHALL: single writes adr 1..10 data 101..110, cyc dropped between each, then single reads adr 1..10 -> each read ack exactly LATENCY cycles after accept, dat_o 101..110.
REQ-033 SHALL: back-to-back writes adr 11..20 data 211..220 in one cycle, then reads -> 10 consecutive acks, wb_stall never 1, dat_o 211..220 in order.
REQ-034 SHALL: DAT_WIDTH=16, write 16'hAAAA to adr 5, then write 16'h1234 with sel=2'b01 -> read adr 5 returns 16'hAA34.
REQ-035 SHALL: MAX_OUT=1, LATENCY=2, 4 back-to-back reads -> wb_stall high after each accept until its ack, one accept per 2 cycles, 4 acks total.
REQ-036 SHALL: 3 reads accepted then wb_cyc=0 before first ack -> no ack ever issued, counter 0, next cycle's request accepted normally.
REQ-037 SHALL: with WB_SLAVE_ERR_EN, write to adr 1024 (DEPTH=1024) -> wb_err after LATENCY, wb_ack 0, adr 0 unchanged; without macro -> wb_ack, adr 0 overwritten.
